// File: rtl/watch_wb_cfg.sv
// Wishbone classic register slave that range-checks an HH:M:M time word and
// hands it to the watch core as a held cfg value plus a one-cycle dvalid pulse.
module watch_wb_cfg #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned HOUR_MAX  = 23
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        smode_i,
    output logic        dvalid_o,
    output logic [11:0] cfg_o
);

    localparam logic [4:0] HOUR_MAX_L = 5'(HOUR_MAX);

    logic        sel_hit_s;
    logic        req_s;
    logic [1:0]  off_s;
    logic        cfg_wr_s;
    logic        stat_wr_s;
    logic        ctrl_wr_s;
    logic [11:0] cand_s;
    logic        accept_s;
    logic [1:0]  status_set_s;
    logic [1:0]  status_clr_s;
    logic [31:0] rdata_s;

    logic [1:0]  status_r;
    logic        apply_en_r;
    logic [7:0]  count_r;

    logic        unused_s;
    assign unused_s = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:12]};

    function automatic logic cfg_legal(input logic [11:0] c);
        return (c[3:0] <= 4'd9) && (c[6:4] <= 3'd5) && (c[11:7] <= HOUR_MAX_L);
    endfunction

    // Decode the bus request, build the candidate cfg and select read data.
    always_comb begin
        sel_hit_s = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        req_s     = sel_hit_s && !wbs_ack_o;
        off_s     = wbs_adr_i[3:2];
        cfg_wr_s  = req_s && wbs_we_i && (off_s == 2'd0);
        stat_wr_s = req_s && wbs_we_i && (off_s == 2'd1);
        ctrl_wr_s = req_s && wbs_we_i && (off_s == 2'd2);
        cand_s    = {(wbs_sel_i[1] ? wbs_dat_i[11:8] : cfg_o[11:8]),
                     (wbs_sel_i[0] ? wbs_dat_i[7:0]  : cfg_o[7:0])};
        accept_s  = cfg_wr_s && cfg_legal(cand_s) && apply_en_r && !smode_i;
        status_set_s = {cfg_wr_s && !accept_s, accept_s};
        if (stat_wr_s) begin
            status_clr_s = wbs_dat_i[1:0];
        end else begin
            status_clr_s = 2'b00;
        end
        case (off_s)
            2'd0:    rdata_s = {20'd0, cfg_o};
            2'd1:    rdata_s = {29'd0, smode_i, status_r};
            2'd2:    rdata_s = {31'd0, apply_en_r};
            2'd3:    rdata_s = {24'd0, count_r};
            default: rdata_s = 32'd0;
        endcase
    end

    // Register bank, single-cycle ack and registered read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= 32'd0;
            dvalid_o   <= 1'b0;
            cfg_o      <= 12'd0;
            status_r   <= 2'b00;
            apply_en_r <= 1'b0;
            count_r    <= 8'd0;
        end else begin
            wbs_ack_o <= req_s;
            wbs_dat_o <= (req_s && !wbs_we_i) ? rdata_s : 32'd0;
            dvalid_o  <= accept_s;
            // Set after clear so a coincident set wins.
            status_r  <= (status_r & ~status_clr_s) | status_set_s;
            if (accept_s) begin
                cfg_o   <= cand_s;
                count_r <= count_r + 8'd1;
            end else begin
                cfg_o   <= cfg_o;
                count_r <= count_r;
            end
            if (ctrl_wr_s) begin
                apply_en_r <= wbs_dat_i[0];
            end else begin
                apply_en_r <= apply_en_r;
            end
        end
    end

endmodule

// File: doc/watch_wb_cfg.md
Name: watch_wb_cfg

Overview:
- Wishbone classic slave that sits directly upstream of the watch core and produces its `dvalid`/`cfg` configuration inputs.
- Software writes an initial HH:M:M time word. The block range-checks it, holds it, and issues a one-cycle apply pulse to the watch core.
- Status, a control register and an accepted-write counter are readable over the bus.

Parameters:
- BASE_ADDR, 32'h3000_0000, base of the 16-byte register window (address bits [31:4] compared).
- HOUR_MAX, 23, highest legal hour value in cfg[11:7].

Ports:
- clk_i  in  1  system clock; the single clock of the block.
- rst_i  in  1  synchronous reset, active-high.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- smode_i  in  1  safe mode; while high, configuration applies are suppressed.
- dvalid_o  out  1  one-cycle pulse: cfg_o is new and must be loaded by the watch core.
- cfg_o  out  12  held configuration: [3:0] minute units, [6:4] minute tens, [11:7] hours.

Behaviour:
- Reset (rst_i high at a clk_i edge) forces all registers to zero:
  - wbs_ack_o=0, wbs_dat_o=0, dvalid_o=0, cfg_o=0;
  - STATUS=0, CTRL=0 (apply disabled), count=0.
- Bus select: sel_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4]==BASE_ADDR[31:4]).
- Acknowledge timing:
  - Request seen in cycle N with wbs_ack_o=0 -> wbs_ack_o=1 in cycle N+1, exactly one cycle.
  - wbs_ack_o returns to 0 in N+2 even if stb is held (no back-to-back ack).
  - No ack when the address is outside the window.
- Register map (offset = wbs_adr_i[3:2]):
  - 0 CFG: R/W.
  - 1 STATUS: read; write-1-to-clear on bits [1:0].
  - 2 CTRL: R/W, bit0 = apply_en.
  - 3 COUNT: read-only, 8-bit.
  - Writes to COUNT are acked and ignored.
- Read data:
  - Registered, valid in the same cycle as wbs_ack_o.
  - Unused bits read 0.
  - wbs_dat_o=0 whenever wbs_ack_o=0.
- CFG write, candidate value:
  - cand[7:0] = sel[0] ? dat[7:0] : cfg_o[7:0].
  - cand[11:8] = sel[1] ? dat[11:8] : cfg_o[11:8].
  - sel[3:2] are ignored.
- CFG write, legality: legal = cand[3:0]<=9 and cand[11:7]<=HOUR_MAX. cand[6:4] (0..7) is legal only if <=5.
- CFG write, accept: if legal & apply_en & !smode_i, evaluated in the cycle the ack is driven:
  - cfg_o <= cand;
  - dvalid_o=1 in that same cycle (coincident with ack), 0 the next;
  - STATUS.acc (bit0) <= 1;
  - count <= count+1, wrapping 255->0.
- CFG write, reject: otherwise:
  - cfg_o unchanged, no dvalid_o pulse;
  - STATUS.rej (bit1) <= 1;
  - count unchanged.
- STATUS bits:
  - acc and rej are sticky and may both be 1.
  - A write to STATUS with dat[0]/dat[1] set clears the respective bit.
  - If a set and a clear land in the same cycle, set wins (cannot occur with one master; define it anyway).
  - STATUS bit2 = live smode_i, sampled into the read data register.
- smode_i edges: no effect on cfg_o. cfg_o keeps its value; the watch core itself zeroes its cfg in safe mode.
- CFG read returns cfg_o in [11:0].
- Reset mid-transaction:
  - Pending ack is dropped, no dvalid_o.
  - The master must retry; the retried request is acked normally after reset releases.
- dvalid_o is never high on two consecutive cycles.

Test Plan:
- Reset, then read all 4 offsets -> ack 1 cycle after stb; data 0,0,0,0; dvalid_o stays 0.
- Write CTRL=1, then CFG=0x000009B7 with sel=4'b0011 -> cfg_o=12'h9B7 (hours 19, tens 3, units 7); dvalid_o high exactly 1 cycle, coincident with ack; STATUS=0x1; COUNT=1.
- Write CFG=0x00000C00 (hours 24) -> rejected: cfg_o stays 0x9B7, no dvalid_o, STATUS bit1=1, COUNT=1. Repeat with units=0xA and tens=6 -> both rejected.
- Write CFG with sel=4'b0001, data 0x25 -> cfg_o=12'h925, dvalid pulse. Then write STATUS=0x3 -> STATUS reads 0x0 with smode_i=0.
- smode_i=1, write legal CFG=0x123 -> acked, no dvalid_o, rej=1, STATUS bit2=1. Also CTRL=0 with a legal write -> rejected.
- 256 accepted writes -> COUNT wraps to 0.
- Access at BASE_ADDR+0x10 -> no ack.
- Assert rst_i in the cycle after stb -> no ack, no dvalid_o; all registers 0.
